// File: rtl/ps2_letter_source.sv
// PS/2 keyboard front end: deserializes frames, decodes Set-2 make/break codes and emits
// one ASCII letter (or Enter) per key press. Define PS2_PARITY_CHECK_EN to enforce odd parity.
module ps2_letter_source #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] curr_letter,
  output logic       C,
  output logic       backspace,
  output logic       frame_err,
  output logic [3:0] o_rx_state,
  output logic [1:0] o_dec_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    RX_IDLE   = 4'b0001,
    RX_DATA   = 4'b0010,
    RX_PARITY = 4'b0100,
    RX_STOP   = 4'b1000
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_NORM    = 2'd0,
    DEC_BRK     = 2'd1,
    DEC_EXT     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_t;

  rx_state_t        r_rx_state;
  dec_state_t       r_dec_state;
  logic             r_clk_s1;
  logic             r_clk_s2;
  logic             r_clk_prev;
  logic             r_dat_s1;
  logic             r_dat_s2;
  logic [CNT_W-1:0] r_to_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_held;
  logic [7:0]       r_curr_letter;
  logic             r_c;
  logic             r_bs;
  logic             r_frame_err;

  logic             w_fall;
  logic             w_bit;
  logic             w_par_ok;
  logic             w_timeout;
  logic             w_byte_valid;
  logic             w_stop_err;
  logic [8:0]       w_lookup;

  // Set-2 letter make codes; bit 8 flags a hit.
  function automatic logic [8:0] scan_to_ascii(input logic [7:0] code);
    case (code)
      8'h1C: return {1'b1, 8'h41};
      8'h32: return {1'b1, 8'h42};
      8'h21: return {1'b1, 8'h43};
      8'h23: return {1'b1, 8'h44};
      8'h24: return {1'b1, 8'h45};
      8'h2B: return {1'b1, 8'h46};
      8'h34: return {1'b1, 8'h47};
      8'h33: return {1'b1, 8'h48};
      8'h43: return {1'b1, 8'h49};
      8'h3B: return {1'b1, 8'h4A};
      8'h42: return {1'b1, 8'h4B};
      8'h4B: return {1'b1, 8'h4C};
      8'h3A: return {1'b1, 8'h4D};
      8'h31: return {1'b1, 8'h4E};
      8'h44: return {1'b1, 8'h4F};
      8'h4D: return {1'b1, 8'h50};
      8'h15: return {1'b1, 8'h51};
      8'h2D: return {1'b1, 8'h52};
      8'h1B: return {1'b1, 8'h53};
      8'h2C: return {1'b1, 8'h54};
      8'h3C: return {1'b1, 8'h55};
      8'h2A: return {1'b1, 8'h56};
      8'h1D: return {1'b1, 8'h57};
      8'h22: return {1'b1, 8'h58};
      8'h35: return {1'b1, 8'h59};
      8'h1A: return {1'b1, 8'h5A};
      default: return 9'h000;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;
  assign w_bit  = r_dat_s2;

`ifdef PS2_PARITY_CHECK_EN
  logic r_par;
  assign w_par_ok = ^{r_shift, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  // A falling edge in the expiry cycle keeps the frame alive.
  assign w_timeout    = (r_rx_state != RX_IDLE) && !w_fall && (r_to_cnt == TO_LAST);
  assign w_byte_valid = w_fall && (r_rx_state == RX_STOP) && w_bit && w_par_ok;
  assign w_stop_err   = w_fall && (r_rx_state == RX_STOP) && !(w_bit && w_par_ok);
  assign w_lookup     = scan_to_ascii(r_shift);

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_rx_state  <= RX_IDLE;
      r_to_cnt    <= '0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_frame_err <= w_stop_err | w_timeout;
      if (w_fall || (r_rx_state == RX_IDLE) || w_timeout)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;

      if (w_timeout) begin
        r_rx_state <= RX_IDLE;
      end else if (w_fall) begin
        case (r_rx_state)
          RX_IDLE: begin
            if (!w_bit) begin
              r_rx_state <= RX_DATA;
              r_bit_cnt  <= 3'd0;
            end
          end
          RX_DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_rx_state <= RX_PARITY;
          end
          RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_par <= w_bit;
`endif
            r_rx_state <= RX_STOP;
          end
          RX_STOP:  r_rx_state <= RX_IDLE;
          default:  r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_dec_state   <= DEC_NORM;
      r_held        <= 8'h00;
      r_curr_letter <= 8'h00;
      r_c           <= 1'b0;
      r_bs          <= 1'b0;
    end else begin
      r_c  <= 1'b0;
      r_bs <= 1'b0;
      if (w_byte_valid) begin
        case (r_dec_state)
          DEC_NORM: begin
            if (r_shift == 8'hF0) begin
              r_dec_state <= DEC_BRK;
            end else if (r_shift == 8'hE0) begin
              r_dec_state <= DEC_EXT;
            end else if (r_shift != r_held) begin
              // Only a new key emits; typematic repeats of the held key are dropped.
              r_held <= r_shift;
              if (r_shift == 8'h5A) begin
                r_curr_letter <= 8'h0D;
                r_c           <= 1'b1;
              end else if (r_shift == 8'h66) begin
                r_bs <= 1'b1;
              end else if (w_lookup[8]) begin
                r_curr_letter <= w_lookup[7:0];
                r_c           <= 1'b1;
              end
            end
          end
          DEC_BRK: begin
            if (r_shift == r_held) r_held <= 8'h00;
            r_dec_state <= DEC_NORM;
          end
          DEC_EXT: begin
            if (r_shift == 8'hF0) r_dec_state <= DEC_EXT_BRK;
            else                  r_dec_state <= DEC_NORM;
          end
          DEC_EXT_BRK: r_dec_state <= DEC_NORM;
          default:     r_dec_state <= DEC_NORM;
        endcase
      end
    end
  end

  assign curr_letter = r_curr_letter;
  assign C           = r_c;
  assign backspace   = r_bs;
  assign frame_err   = r_frame_err;
  assign o_rx_state  = r_rx_state;
  assign o_dec_state = r_dec_state;

endmodule

// File: tb/tb_ps2_letter_source.sv
// Directed bench for ps2_letter_source: bit-banged PS/2 frames, strobe monitor and
// an expected-letter queue; honours PS2_PARITY_CHECK_EN for the parity case.
module tb_ps2_letter_source;

  localparam int TO_CYC = 300;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] curr_letter;
  logic       C;
  logic       backspace;
  logic       frame_err;
  logic [3:0] o_rx_state;
  logic [1:0] o_dec_state;

  ps2_letter_source #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .Clk(Clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .curr_letter(curr_letter), .C(C), .backspace(backspace), .frame_err(frame_err),
    .o_rx_state(o_rx_state), .o_dec_state(o_dec_state)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  // Scoreboard state
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int c_high = 0, c_rise = 0, bs_high = 0, fe_high = 0, fe_rise = 0, overlap = 0;
  int exp_c = 0, exp_bs = 0, exp_fe = 0;
  int lat;
  bit c_prev = 1'b0, fe_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (C) begin
      c_high++;
      if (exp_q.size() > 0) check("letter", {24'h0, curr_letter}, {24'h0, exp_q.pop_front()});
      else check("c_unexpected", {31'h0, C}, 32'h0);
    end
    if (C && !c_prev) c_rise++;
    if (backspace) bs_high++;
    if (frame_err) fe_high++;
    if (frame_err && !fe_prev) fe_rise++;
    if ((C && frame_err) || (C && backspace)) overlap++;
    c_prev  = C;
    fe_prev = frame_err;
  end

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Sends the first nbits bits of a frame; lat = cycles from final clock fall to a strobe.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] fr;
    fr  = {~bad_stop, (~(^b)) ^ flip_par, b, 1'b0};
    lat = 99;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (7) tick();
      ps2_clk = 1'b0;
      for (int k = 1; k <= 15; k++) begin
        tick();
        if (i == nbits - 1 && lat == 99 && (C || backspace || frame_err)) lat = k;
      end
      ps2_clk = 1'b1;
      repeat (8) tick();
    end
    ps2_data = 1'b1;
    repeat (20) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  initial begin
    repeat (4) tick();
    reset = 1'b0;
    tick();
    check("rst_letter", {24'h0, curr_letter}, 32'h00);
    check("rst_c", {31'h0, C}, 32'h0);
    check("rst_bs", {31'h0, backspace}, 32'h0);
    check("rst_fe", {31'h0, frame_err}, 32'h0);
    check("rst_rx", {28'h0, o_rx_state}, 32'h1);
    check("rst_dec", {30'h0, o_dec_state}, 32'h0);

    // A: one strobe, letter held afterwards
    exp_q.push_back(8'h41); exp_c++;
    send_byte(8'h1C);
    check("lat_A", lat, 3);
    check("c_A", c_high, exp_c);
    repeat (120) tick();
    check("hold_letter", {24'h0, curr_letter}, 32'h41);
    check("hold_c", c_high, exp_c);

    // Repeat suppressed, re-press after break emits
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    exp_q.push_back(8'h41); exp_c++;
    send_byte(8'h1C);
    send_byte(8'h1C);
    check("c_repeat", c_high, exp_c);

    // Enter then Backspace
    exp_q.push_back(8'h0D); exp_c++;
    send_byte(8'h5A);
    check("enter_letter", {24'h0, curr_letter}, 32'h0D);
    send_byte(8'hF0);
    send_byte(8'h5A);
    exp_bs++;
    send_byte(8'h66);
    check("bs_count", bs_high, exp_bs);
    check("bs_letter", {24'h0, curr_letter}, 32'h0D);
    check("bs_c", c_high, exp_c);

    // Extended make/break discarded
    send_byte(8'hE0);
    send_byte(8'h1C);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("ext_c", c_high, exp_c);
    check("ext_bs", bs_high, exp_bs);
    check("ext_dec", {30'h0, o_dec_state}, 32'h0);
    exp_q.push_back(8'h42); exp_c++;
    send_byte(8'h32);
    check("ext_next", {24'h0, curr_letter}, 32'h42);

    // Flipped parity
`ifdef PS2_PARITY_CHECK_EN
    exp_fe++;
`else
    exp_q.push_back(8'h41); exp_c++;
`endif
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    check("par_c", c_high, exp_c);
    check("par_fe", fe_high, exp_fe);

    // Timeout after start + 4 data bits
    send_frame(8'h0F, 1'b0, 1'b0, 5);
    check("to_rx_mid", {28'h0, o_rx_state}, 32'h2);
    exp_fe++;
    repeat (TO_CYC + 50) tick();
    check("to_fe", fe_high, exp_fe);
    check("to_rx_idle", {28'h0, o_rx_state}, 32'h1);
    exp_q.push_back(8'h43); exp_c++;
    send_byte(8'h21);
    check("to_next_letter", {24'h0, curr_letter}, 32'h43);
    check("to_next_fe", fe_high, exp_fe);

    // Bad stop bit
    exp_fe++;
    send_frame(8'h1D, 1'b0, 1'b1, 11);
    check("stop_fe", fe_high, exp_fe);
    check("stop_c", c_high, exp_c);

    // Reset mid-frame
    send_frame(8'h55, 1'b0, 1'b0, 4);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("mid_rst_letter", {24'h0, curr_letter}, 32'h00);
    check("mid_rst_rx", {28'h0, o_rx_state}, 32'h1);
    exp_q.push_back(8'h42); exp_c++;
    send_byte(8'h32);
    check("mid_rst_next", {24'h0, curr_letter}, 32'h42);

    // Totals
    repeat (10) tick();
    check("tot_c_cycles", c_high, exp_c);
    check("tot_c_pulses", c_rise, exp_c);
    check("tot_bs", bs_high, exp_bs);
    check("tot_fe_cycles", fe_high, exp_fe);
    check("tot_fe_pulses", fe_rise, exp_fe);
    check("overlap", overlap, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
